// File: rtl/mdr_mem_ctrl_pkg.sv
// Shared definitions for the memory data register and its sequencer:
// access-size codes, state encoding and the size-to-byte-lane mapping.
package mdr_mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      READ  = ST_READ,
      WRITE = ST_WRITE
   } state_t;

   // Lane mask for up to 8 lanes; callers truncate to their lane count.
   // Size 2'b11 falls through to a full word.
   function automatic logic [7:0] size_be(input logic [1:0] sz);
      logic [7:0] be;
      case (sz)
         SZ_BYTE: be = 8'h01;
         SZ_HALF: be = 8'h03;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mdr_extend.sv
// Combinational sign/zero extender for sub-word loads.
// Ports: i_data (raw word), i_size, i_sext -> o_data (extended word).
module mdr_extend
   import mdr_mem_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       i_size,
   input  logic             i_sext,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] w_mask;
   logic             w_msb;

   always_comb begin
      w_mask = '1;
      w_msb  = i_data[WIDTH-1];
      case (i_size)
         SZ_BYTE: begin
            w_mask = WIDTH'(8'hFF);
            w_msb  = i_data[7];
         end
         SZ_HALF: begin
            w_mask = WIDTH'(16'hFFFF);
            w_msb  = i_data[15];
         end
         default: ;
      endcase
      o_data = i_data & w_mask;
      // Bits above the field become copies of the field's MSB.
      if (i_sext && w_msb)
         o_data = o_data | ~w_mask;
   end

endmodule

// File: rtl/mdr_mem_ctrl.sv
// Memory data register with read/write handshake sequencer and timeout.
// Ports: bus side (bus_in, bus_load, mdr_out), control (rd/wr_start,
// size, sign_ext, busy, done, err), memory side (mem_*).
module mdr_mem_ctrl
   import mdr_mem_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   bus_in,
   input  logic               bus_load,
   input  logic               rd_start,
   input  logic               wr_start,
   input  logic [1:0]         size,
   input  logic               sign_ext,
   output logic               mem_req,
   output logic               mem_we,
   output logic [WIDTH/8-1:0] mem_be,
   output logic [WIDTH-1:0]   mem_wdata,
   input  logic [WIDTH-1:0]   mem_rdata,
   input  logic               mem_ack,
   output logic [WIDTH-1:0]   mdr_out,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int NB = WIDTH / 8;
   // Count value of the last wait cycle still allowed to see an ack.
   localparam logic [CNT_W-1:0] LAST =
      CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           r_state;
   logic [WIDTH-1:0] r_mdr;
   logic             r_req;
   logic             r_we;
   logic [NB-1:0]    r_be;
   logic [1:0]       r_size;
   logic             r_sext;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_err;
   logic [NB-1:0]    w_be;
   logic [WIDTH-1:0] w_ext;

   assign w_be = NB'(size_be(size));

   mdr_extend #(.WIDTH(WIDTH)) u_ext (
      .i_data (mem_rdata),
      .i_size (r_size),
      .i_sext (r_sext),
      .o_data (w_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_mdr   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_size  <= SZ_WORD;
         r_sext  <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               // Load lands on the same edge as a start, so a write
               // sends the freshly loaded value.
               if (bus_load)
                  r_mdr <= bus_in;
               if (rd_start && wr_start) begin
                  r_err <= 1'b1;
               end else if (rd_start || wr_start) begin
                  r_state <= rd_start ? READ : WRITE;
                  r_req   <= 1'b1;
                  r_we    <= wr_start;
                  r_be    <= w_be;
                  r_size  <= size;
                  r_sext  <= sign_ext;
               end
            end
            READ, WRITE: begin
               if (mem_ack || (TIMEOUT != 0 && r_cnt == LAST)) begin
                  if (mem_ack && r_state == READ)
                     r_mdr <= w_ext;
                  r_done  <= mem_ack;
                  r_err   <= !mem_ack;
                  r_state <= IDLE;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_be    <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign mem_be    = r_be;
   assign mem_wdata = r_mdr;
   assign mdr_out   = r_mdr;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
Parametrised memory data register with its own memory-handshake sequencer. It supports sub-word loads with sign/zero extension, byte-lane write enables and a wait-state timeout. It sits between the internal CPU bus and the memory port, replacing the fixed 32-bit MDR and its 2:1 input mux. The control unit issues single-cycle start strobes and waits for done/err instead of counting memory cycles itself.

Parameters:
WIDTH, 32, data width in bits; legal values 16, 32, 64.
TIMEOUT, 16, maximum wait cycles for mem_ack before aborting; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
bus_in  in  WIDTH  data from the internal bus
bus_load  in  1  load mdr_out from bus_in; honoured only in IDLE
rd_start  in  1  begin memory read; single-cycle strobe
wr_start  in  1  begin memory write of the current mdr_out
size  in  2  access size: 00 byte, 01 half, 10 full word, 11 treated as full word
sign_ext  in  1  1 = sign-extend sub-word reads, 0 = zero-extend
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write request, registered
mem_be  out  WIDTH/8  byte-lane enables, registered
mem_wdata  out  WIDTH  write data; equals mdr_out
mem_rdata  in  WIDTH  read data from memory; valid when mem_ack=1
mem_ack  in  1  memory completion, one cycle
mdr_out  out  WIDTH  register contents, driven onto the bus externally
busy  out  1  high in READ or WRITE
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on timeout or illegal start

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - mdr_out=0, mem_req=0, mem_we=0, mem_be=0, busy=0, done=0, err=0.
  - Wait counter=0, state=IDLE.
  - Reset mid-transaction abandons it with no done/err pulse; mem_req drops on the following cycle.
- States: IDLE, READ, WRITE.
- IDLE:
  - bus_load=1 -> mdr_out<=bus_in next edge.
  - rd_start=1 alone -> latch size and sign_ext; go to READ; mem_req=1, mem_we=0 from the next cycle.
  - wr_start=1 alone -> go to WRITE; mem_req=1, mem_we=1.
  - rd_start and wr_start both 1 -> no transaction; err pulses the next cycle.
  - bus_load together with a start -> bus_load is applied first, so a write uses the newly loaded data.
- mem_be is set on entry to READ/WRITE from the latched size and held until return to IDLE:
  - byte -> 1 in lane 0;
  - half -> lanes 0-1;
  - full word -> all ones.
- READ and WRITE:
  - busy=1.
  - rd_start, wr_start and bus_load are ignored; mdr_out stays frozen during WRITE.
  - mem_ack is sampled from the first cycle mem_req is high.
- Read completion, on mem_ack=1:
  - mdr_out<=extend(mem_rdata low lanes, size, sign_ext); upper bits are the replicated MSB of the selected field, or zero.
  - done=1 and state IDLE next cycle; mem_req=0 next cycle.
- Write completion, on mem_ack=1: done=1 and state IDLE next cycle; mdr_out unchanged.
- Latency: start at edge n -> mem_req high in cycle n+1. An ack in cycle n+k (k>=1) -> done and updated mdr_out in cycle n+k+1. Minimum round trip is 2 cycles.
- Timeout (TIMEOUT>0):
  - The counter increments each busy cycle without ack.
  - On the cycle the count reaches TIMEOUT with no ack: state IDLE next cycle, err=1, mdr_out unchanged, mem_req=0.
  - Ack on the same cycle the count reaches TIMEOUT counts as success.
  - The counter clears on entry to IDLE.
- A stray mem_ack in IDLE is ignored.
- done and err are never high together.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding localparams;
  - byte-enable function size->mem_be.
- Sub-module: mdr_extend, a combinational WIDTH-parametrised sign/zero extender (mem_rdata, size, sign_ext -> extended word), reused later by the load unit.
- The FSM, counter and register live in mdr_mem_ctrl.

Test Plan:
1. Bus load then write:
   - Stimulus: reset; bus_in=32'hDEADBEEF with bus_load; wr_start size=10; mem_ack 3 cycles after mem_req.
   - Response: mem_we=1, mem_be=4'hF, mem_wdata=32'hDEADBEEF, done after 4 cycles of busy, mdr_out unchanged.
2. Signed byte read:
   - Stimulus: rd_start size=00 sign_ext=1; mem_rdata=32'h123456F0 with immediate ack.
   - Response: mdr_out=32'hFFFFFFF0, mem_be=4'h1, done 2 cycles after start.
3. Zero-extended half read:
   - Stimulus: mem_rdata=32'hAAAA8001, size=01, sign_ext=0.
   - Response: mdr_out=32'h00008001, mem_be=4'h3.
4. Timeout:
   - Stimulus: TIMEOUT=4, rd_start, no ack.
   - Response: err pulse after 4 busy cycles, mem_req low after, mdr_out retains its prior value.
   - Re-run with ack exactly on cycle 4 -> done, not err.
5. Conflicts:
   - Simultaneous rd_start and wr_start in IDLE -> err, no mem_req.
   - bus_load=1 during WRITE -> mdr_out and mem_wdata unchanged.
6. Reset mid-READ:
   - Stimulus: reset asserted in the 2nd wait cycle.
   - Response: next cycle mdr_out=0, mem_req=0, busy=0, no done/err.
   - Repeat test 2 at WIDTH=64: size=10 -> mem_be=8'hFF.
